// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises the eight per-format RAM request bundles onto the
// single data-RAM port. The granted channel's access runs through a req/ack
// handshake with the RAM. Read data is captured for the core. An atomic
// read-modify-write on channel 2 runs as a read followed by a write.
//
// Handshake: oMEM_REQ rises with oMEM_WE, oMEM_ADDR and oMEM_WDATA valid and
// holds them unchanged until the RAM answers with a one-cycle iMEM_ACK. The
// same holds until the transaction times out. A transaction ends on the edge
// that samples iMEM_ACK. An ack seen while no request is pending is ignored.
module mem_arbiter #(
    parameter int N_CH    = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    input  logic [N_CH-1:0]      iREQ_CE,
    input  logic [N_CH-1:0]      iREQ_RD,
    input  logic [N_CH-1:0]      iREQ_WR,
    input  logic [8*N_CH-1:0]    iREQ_ADDR,
    input  logic [32*N_CH-1:0]   iREQ_DATA,
    output logic                 oMEM_REQ,
    output logic                 oMEM_WE,
    output logic [7:0]           oMEM_ADDR,
    output logic [31:0]          oMEM_WDATA,
    input  logic                 iMEM_ACK,
    input  logic [31:0]          iMEM_RDATA,
    output logic [31:0]          oRD_DATA,
    output logic [N_CH-1:0]      oDONE,
    output logic                 oSTALL,
    output logic                 oERR,
    output logic [1:0]           oSTATE
);
    localparam int              GW        = $clog2(N_CH);
    localparam logic [7:0]      CNT_LIMIT = 8'(TIMEOUT - 1);
    localparam logic [GW-1:0]   ATOMIC_CH = GW'(2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state, state_n;
    logic [GW-1:0]   grant, grant_n, pick;
    logic [7:0]      addr_q, addr_n;
    logic [7:0]      cnt, cnt_n;
    logic            rmw_q, rmw_n;
    logic            err_q, err_n;
    logic [31:0]     rd_q, rd_n;
    logic [N_CH-1:0] active;
    logic            any_active;
    logic            sel_rd, sel_wr, pick_atomic;
    logic [7:0]      sel_addr;

    // Lowest-index active channel wins; the others wait, held by the stall.
    always_comb begin
        active = iREQ_CE & (iREQ_RD | iREQ_WR);
        pick   = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (active[k]) pick = GW'(k);
        end
    end

    assign any_active  = |active;
    assign sel_rd      = iREQ_RD[pick];
    assign sel_wr      = iREQ_WR[pick];
    assign sel_addr    = iREQ_ADDR[{pick, 3'b000} +: 8];
    assign pick_atomic = (pick == ATOMIC_CH);

    // Register the FSM state and the per-transaction context.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state  <= S_IDLE;
            grant  <= '0;
            addr_q <= '0;
            cnt    <= '0;
            rmw_q  <= 1'b0;
            err_q  <= 1'b0;
            rd_q   <= '0;
        end else begin
            state  <= state_n;
            grant  <= grant_n;
            addr_q <= addr_n;
            cnt    <= cnt_n;
            rmw_q  <= rmw_n;
            err_q  <= err_n;
            rd_q   <= rd_n;
        end
    end

    // Next-state sequencing and RAM-port drive for the granted transaction.
    always_comb begin
        state_n    = state;
        grant_n    = grant;
        addr_n     = addr_q;
        cnt_n      = cnt;
        rmw_n      = rmw_q;
        err_n      = err_q;
        rd_n       = rd_q;
        oMEM_REQ   = 1'b0;
        oMEM_WE    = 1'b0;
        oMEM_ADDR  = addr_q;
        oMEM_WDATA = '0;
        oDONE      = '0;
        oERR       = 1'b0;
        oSTALL     = 1'b0;
        case (state)
            S_IDLE: begin
                oSTALL = any_active;
                if (any_active) begin
                    grant_n = pick;
                    addr_n  = sel_addr;
                    // RD+WR only means read-modify-write on the atomic channel;
                    // on any other channel it degrades to a plain write.
                    rmw_n   = sel_rd & sel_wr & pick_atomic;
                    err_n   = 1'b0;
                    cnt_n   = '0;
                    state_n = (sel_rd & ~(sel_wr & ~pick_atomic)) ? S_RD : S_WR;
                end
            end
            S_RD: begin
                oMEM_REQ = 1'b1;
                oSTALL   = 1'b1;
                if (iMEM_ACK) begin
                    rd_n    = iMEM_RDATA;
                    cnt_n   = '0;
                    state_n = rmw_q ? S_WR : S_DONE;
                end else if (cnt == CNT_LIMIT) begin
                    err_n   = 1'b1;
                    rd_n    = '0;
                    cnt_n   = '0;
                    state_n = S_DONE;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            S_WR: begin
                oMEM_REQ   = 1'b1;
                oMEM_WE    = 1'b1;
                oSTALL     = 1'b1;
                // Live from the channel so an RMW write can be built from oRD_DATA.
                oMEM_WDATA = iREQ_DATA[{grant, 5'b00000} +: 32];
                if (iMEM_ACK) begin
                    cnt_n   = '0;
                    state_n = S_DONE;
                end else if (cnt == CNT_LIMIT) begin
                    err_n   = 1'b1;
                    rd_n    = '0;
                    cnt_n   = '0;
                    state_n = S_DONE;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            S_DONE: begin
                oDONE[grant] = 1'b1;
                oERR         = err_q;
                state_n      = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign oRD_DATA = rd_q;
    assign oSTATE   = state;

endmodule
